// File: rtl/block_array_ctrl.sv
// Scheduler and owner of the 8x8 stacker block array: clear sweep, optional scroll sweep
// (BLOCK_ARRAY_CTRL_SCROLL_EN), single-row writes and a registered pixel read port.
module block_array_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_req,
  input  logic       scroll_req,
  input  logic       wr_req,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       rd_valid,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic       rd_pixel,
  output logic       busy,
  output logic       clr_done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CLEAR  = 2'b01,
    ST_SCROLL = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] arr_q [8];
  logic [7:0] arr_d [8];
  logic       clr_pend_q, clr_pend_d;
  logic       scr_pend_q, scr_pend_d;
  logic       wr_ack_q, wr_ack_d;
  logic       clr_done_q, clr_done_d;
  logic       busy_q;
  logic       rd_pixel_q;

`ifndef BLOCK_ARRAY_CTRL_SCROLL_EN
  logic unused_scroll;
  assign unused_scroll = scroll_req;
`endif

  // Next-state, sweep and write arbitration logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arr_d      = arr_q;
    wr_ack_d   = 1'b0;
    clr_done_d = 1'b0;
    clr_pend_d = clr_pend_q | clr_req;
`ifdef BLOCK_ARRAY_CTRL_SCROLL_EN
    scr_pend_d = scr_pend_q | scroll_req;
`else
    scr_pend_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          // A request arriving on the start cycle re-arms the flag
          state_d    = ST_CLEAR;
          cnt_d      = 3'd0;
          clr_pend_d = clr_req;
`ifdef BLOCK_ARRAY_CTRL_SCROLL_EN
        end else if (scr_pend_q) begin
          state_d    = ST_SCROLL;
          cnt_d      = 3'd7;
          scr_pend_d = scroll_req;
`endif
        end else if (wr_req && !wr_ack_q) begin
          arr_d[wr_row] = wr_data;
          wr_ack_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        arr_d[cnt_q] = 8'h00;
        if (cnt_q == 3'd7) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef BLOCK_ARRAY_CTRL_SCROLL_EN
      ST_SCROLL: begin
        // Bottom-up copy so every source row is read before it is overwritten
        if (cnt_q == 3'd0) begin
          arr_d[0] = 8'h00;
          state_d  = ST_IDLE;
        end else begin
          arr_d[cnt_q] = arr_q[cnt_q - 3'd1];
          cnt_d        = cnt_q - 3'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, array and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      clr_pend_q <= 1'b0;
      scr_pend_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_pixel_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        arr_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      scr_pend_q <= scr_pend_d;
      wr_ack_q   <= wr_ack_d;
      clr_done_q <= clr_done_d;
      busy_q     <= (state_d != ST_IDLE);
      rd_pixel_q <= rd_valid ? arr_q[rd_row][3'd7 - rd_col] : 1'b0;
      for (int i = 0; i < 8; i++) begin
        arr_q[i] <= arr_d[i];
      end
    end
  end

  assign wr_ack   = wr_ack_q;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
  assign rd_pixel = rd_pixel_q;
  assign state    = state_q;

endmodule
